// File: rtl/sar_ctrl.sv
// Successive-approximation register controller: sequences the track/hold switch
// and the DAC trial code, one comparator decision per clock, MSB first.
module sar_ctrl #(
   parameter int NUM_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_sig,
   input  logic                comp_out,
   output logic                sample_en,
   output logic [NUM_BITS-1:0] dac_code,
   output logic [NUM_BITS-1:0] result,
   output logic                result_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SAMPLE  = 2'd1;
   localparam logic [1:0] CONVERT = 2'd2;

   localparam logic [NUM_BITS-1:0] MSB_ONLY  = {1'b1, {(NUM_BITS-1){1'b0}}};
   localparam logic [IW-1:0]       TOP_INDEX = IW'(NUM_BITS - 1);

   logic [1:0]          state, state_d;
   logic [IW-1:0]       index, index_d;
   logic [NUM_BITS-1:0] dac_d, result_d, trial;
   logic                valid_d, overrun_d;

   // NOTE: every variable gets a default at the top of the block, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state;
      index_d   = index;
      dac_d     = dac_code;
      result_d  = result;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
      trial     = dac_code;

      case (state)
         IDLE: begin
            if (sample_sig) begin
               state_d = SAMPLE;
               dac_d   = MSB_ONLY;
            end
         end

         SAMPLE: begin
            state_d   = CONVERT;
            index_d   = TOP_INDEX;
            overrun_d = sample_sig;
         end

         CONVERT: begin
            trial[index] = comp_out;
            if (index != '0) begin
               trial[index - IW'(1)] = 1'b1;
               index_d   = index - IW'(1);
               dac_d     = trial;
               overrun_d = sample_sig;
            end else begin
               // Bit 0 decided: publish, and a start request on this very edge
               // is accepted so conversions can run back to back.
               result_d = trial;
               valid_d  = 1'b1;
               if (sample_sig) begin
                  state_d = SAMPLE;
                  dac_d   = MSB_ONLY;
               end else begin
                  state_d = IDLE;
                  dac_d   = trial;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         index        <= TOP_INDEX;
         sample_en    <= 1'b0;
         dac_code     <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_d;
         index        <= index_d;
         sample_en    <= (state_d == SAMPLE);
         dac_code     <= dac_d;
         result       <= result_d;
         result_valid <= valid_d;
         busy         <= (state_d != IDLE);
         overrun      <= overrun_d;
      end
   end

endmodule

// File: tb/tb_sar_ctrl.sv
// Scoreboard bench for sar_ctrl: an ideal comparator tracks an analog level
// given as a code; expected results come from binary-search arithmetic.
module tb_sar_ctrl;

   localparam int NB = 4;

   typedef struct {
      logic [NB-1:0] val;
      int            cyc;
   } exp_t;

   logic          clk, rst_n, sample_sig, comp_out;
   logic          sample_en, result_valid, busy, overrun;
   logic [NB-1:0] dac_code, result;
   logic [NB-1:0] vin;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb[$];
   int   ov_q[$];

   // Model of acceptance: a conversion started at edge s occupies edges up to
   // s+NB+1, and that final edge may already take the next request.
   bit m_active = 0;
   int m_start = 0;

   sar_ctrl #(.NUM_BITS(NB)) dut (
      .clk(clk), .rst_n(rst_n), .sample_sig(sample_sig), .comp_out(comp_out),
      .sample_en(sample_en), .dac_code(dac_code), .result(result),
      .result_valid(result_valid), .busy(busy), .overrun(overrun)
   );

   assign comp_out = (dac_code <= vin);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Issue a one-cycle start pulse from a negedge; returns at the next negedge.
   task automatic issue(input logic [NB-1:0] v);
      int e;
      bit acc;
      e   = cyc + 1;
      acc = !m_active || (e >= m_start + NB + 1);
      sample_sig = 1'b1;
      if (acc) begin
         m_active = 1'b1;
         m_start  = e;
         sb.push_back('{v, cyc + NB + 2});
      end else begin
         ov_q.push_back(cyc + 1);
      end
      @(negedge clk);
      sample_sig = 1'b0;
      if (acc) vin = v;
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      sb.delete();
      ov_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_sample_en"}, sample_en, 0);
      check({tag, "_dac_code"}, dac_code, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_result_valid"}, result_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_overrun"}, overrun, 0);
   endtask

   // Monitor: every expected pulse must appear on exactly its cycle; any other
   // pulse is unexpected.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            check("valid_latency", result_valid, 1);
            check("result_value", result, sb[0].val);
            void'(sb.pop_front());
         end else if (result_valid) begin
            check("unexpected_valid", result_valid, 0);
         end
         if (ov_q.size() > 0 && ov_q[0] <= cyc) begin
            check("overrun_pulse", overrun, 1);
            void'(ov_q.pop_front());
         end else if (overrun) begin
            check("unexpected_overrun", overrun, 0);
         end
      end
   end

   initial begin
      logic [NB-1:0] tr[NB];
      logic [NB-1:0] code;
      logic [NB-1:0] dir_vin[4];

      rst_n = 1'b0;
      sample_sig = 1'b0;
      vin = '0;
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Long idle after reset.
      repeat (100) @(negedge clk) check("idle_busy", busy, 0);
      check("idle_result", result, 0);

      // Directed conversions with full trial-code trajectory.
      dir_vin[0] = 4'd10; dir_vin[1] = 4'd15; dir_vin[2] = 4'd0; dir_vin[3] = 4'd5;
      for (int i = 0; i < 4; i++) begin
         code = '0;
         for (int b = NB - 1; b >= 0; b--) begin
            tr[NB-1-b] = code | NB'(1 << b);
            if (tr[NB-1-b] <= dir_vin[i]) code = tr[NB-1-b];
         end
         issue(dir_vin[i]);
         check("start_dac", dac_code, tr[0]);
         check("start_sample_en", sample_en, 1);
         check("start_busy", busy, 1);
         for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            check("trial_dac", dac_code, tr[k]);
            if (k == 0) check("hold_sample_en", sample_en, 0);
         end
         @(negedge clk);
         check("final_dac", dac_code, dir_vin[i]);
         check("final_idle", busy, 0);
      end

      // Back-to-back: a start pulse every NB+1 cycles.
      for (int i = 0; i < 6; i++) begin
         issue(NB'($urandom_range(0, 15)));
         check("b2b_sample_en", sample_en, 1);
         repeat (NB) begin
            @(negedge clk);
            check("b2b_busy", busy, 1);
            check("b2b_sample_en_low", sample_en, 0);
         end
      end
      repeat (3) @(negedge clk);

      // Start request during CONVERT is dropped with an overrun pulse.
      issue(4'd12);
      @(negedge clk);
      issue(4'd3);
      repeat (NB) @(negedge clk);
      check("overrun_no_restart", busy, 0);

      // Reset while the conversion sits at bit index 2.
      issue(4'd9);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1 check_all_zero("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      issue(4'd6);
      repeat (NB + 2) @(negedge clk);

      // Random traffic, including overlapping requests.
      repeat (60) begin
         repeat ($urandom_range(0, 6)) @(negedge clk);
         issue(NB'($urandom_range(0, 15)));
      end

      repeat (NB + 4) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      check("overrun_queue_drained", ov_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 Parameter NUM_BITS, default 4: converter resolution in bits; legal range 2..16.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sample_sig  input  1  one-cycle start pulse from the sampler; one pulse per conversion request.
REQ-005 comp_out  input  1  comparator result for the current dac_code; 1 = Vin >= Vdac (keep trial bit), 0 = clear trial bit.
REQ-006 sample_en  output  1  track/hold switch control; 1 = track.
REQ-007 dac_code  output  NUM_BITS  trial code driven to the capacitive DAC.
REQ-008 result  output  NUM_BITS  last completed conversion code.
REQ-009 result_valid  output  1  one-cycle pulse when result updates.
REQ-010 busy  output  1  high in SAMPLE and CONVERT states.
REQ-011 overrun  output  1  one-cycle pulse when a sample_sig is dropped.

Function
REQ-012 FSM states SHALL be IDLE, SAMPLE, CONVERT; all outputs registered.
REQ-013 IDLE: on sample_sig=1 SHALL enter SAMPLE next cycle, set sample_en=1, dac_code = MSB-only (1 followed by NUM_BITS-1 zeros).
REQ-014 SAMPLE lasts exactly one cycle; next edge SHALL enter CONVERT, clear sample_en, hold dac_code, load bit index = NUM_BITS-1.
REQ-015 CONVERT: each edge SHALL sample comp_out for bit[index]: comp_out=1 keeps the bit, comp_out=0 clears it; if index>0, SHALL set bit[index-1]=1 and decrement index.
REQ-016 On the edge deciding bit 0, SHALL load result with the final code, pulse result_valid for one cycle, and leave dac_code holding the final code.
REQ-017 Latency: sample_sig seen at edge E0 -> result_valid high after edge E(NUM_BITS+1); minimum sample period NUM_BITS+1 cycles.
REQ-018 After the bit-0 edge the FSM SHALL go to IDLE, or directly to SAMPLE (MSB-only dac_code, sample_en=1) if sample_sig=1 on that same edge (back-to-back, no gap).
REQ-019 sample_sig=1 in SAMPLE, or in CONVERT with index>0, SHALL be ignored and SHALL pulse overrun for one cycle; the conversion in progress SHALL complete unaffected.
REQ-020 busy SHALL be 1 whenever state is SAMPLE or CONVERT, 0 in IDLE.
REQ-021 result SHALL hold its value between conversions; result_valid and overrun SHALL never be high for more than one consecutive cycle unless separate events occur.
REQ-022 comp_out SHALL be ignored outside CONVERT.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, sample_en=0, dac_code=0, result=0, result_valid=0, busy=0, overrun=0, index=NUM_BITS-1.
REQ-024 Reset asserted mid-conversion SHALL abort it with no result_valid; first sample_sig after release SHALL start a clean conversion.
REQ-025 sample_sig coincident with the edge that releases reset SHALL start a conversion only if sampled high on a rising edge with rst_n=1.

Verification
REQ-026 NUM_BITS=4, comparator model comp_out=(dac_code<=10), single sample_sig -> dac_code sequence 1000,1100,1010,1011; result=1010, result_valid after edge E5.
REQ-027 Vin code 15 then 0 on consecutive conversions -> result=1111 then 0000; all trial bits kept then all cleared.
REQ-028 sample_sig every 5 cycles (NUM_BITS=4) -> back-to-back conversions, sample_en high in every 5th cycle, busy never drops, overrun never pulses.
REQ-029 sample_sig at E0 and again at E2 -> overrun pulse after E2; first conversion completes at E5; no second conversion started.
REQ-030 rst_n pulsed low during CONVERT index 2 -> all outputs 0 immediately, no result_valid; next sample_sig yields correct result.
REQ-031 sample_sig held low for 100 cycles after reset -> state IDLE, busy=0, result=0, no pulses on result_valid or overrun.
